// File: rtl/antares_pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package antares_pipeline_sequencer_pkg;

    localparam int unsigned GprIdxW          = 5;
    localparam int unsigned DefaultDivCycles = 32;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StFlush = 2'd2
    } seq_state_e;

endpackage

// File: rtl/antares_load_use_detector.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module antares_load_use_detector
    import antares_pipeline_sequencer_pkg::*;
(
    input  logic [GprIdxW-1:0] id_rs,
    input  logic [GprIdxW-1:0] id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [GprIdxW-1:0] ex_gpr_wa,
    input  logic               ex_mem_to_gpr_select,
    input  logic               ex_gpr_we,
    output logic               load_use
);

    logic rs_hit;
    logic rt_hit;
    logic ex_is_load;

    always_comb begin
        rs_hit     = id_uses_rs && (id_rs == ex_gpr_wa);
        rt_hit     = id_uses_rt && (id_rt == ex_gpr_wa);
        // r0 is hardwired to zero, so a load targeting it creates no dependency
        ex_is_load = ex_gpr_we && ex_mem_to_gpr_select && (ex_gpr_wa != '0);
        load_use   = ex_is_load && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/antares_pipeline_sequencer.sv
// Central stall/flush sequencer for the five-stage pipeline: stall chain,
// divider busy tracking, exception drain/flush FSM and stall-cycle counter.
module antares_pipeline_sequencer
    import antares_pipeline_sequencer_pkg::*;
#(
    parameter int unsigned DIV_CYCLES  = DefaultDivCycles,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_mem_wait,
    input  logic                   mem_mem_wait,
    input  logic [GprIdxW-1:0]     id_rs,
    input  logic [GprIdxW-1:0]     id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [GprIdxW-1:0]     ex_gpr_wa,
    input  logic                   ex_mem_to_gpr_select,
    input  logic                   ex_gpr_we,
    input  logic                   ex_div_start,
    input  logic                   ex_hilo_read,
    input  logic                   mem_exception,
    output logic                   if_stall,
    output logic                   id_stall,
    output logic                   ex_stall,
    output logic                   mem_stall,
    output logic                   wb_stall,
    output logic                   if_flush,
    output logic                   id_flush,
    output logic                   ex_flush,
    output logic                   mem_flush,
    output logic                   exc_redirect,
    output logic                   div_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned DivCntW = $clog2(DIV_CYCLES + 1);
    localparam logic [DivCntW-1:0]     DivLoad  = DivCntW'(DIV_CYCLES);
    localparam logic [DivCntW-1:0]     DivOne   = DivCntW'(1);
    localparam logic [STALL_CNT_W-1:0] StallOne = STALL_CNT_W'(1);

    seq_state_e state_q, state_d;

    logic [DivCntW-1:0]     div_cnt_q, div_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic in_flush;
    logic mem_stall_raw;
    logic ex_stall_raw;
    logic id_stall_raw;
    logic if_stall_raw;

    antares_load_use_detector u_load_use (
        .id_rs                (id_rs),
        .id_rt                (id_rt),
        .id_uses_rs           (id_uses_rs),
        .id_uses_rt           (id_uses_rt),
        .ex_gpr_wa            (ex_gpr_wa),
        .ex_mem_to_gpr_select (ex_mem_to_gpr_select),
        .ex_gpr_we            (ex_gpr_we),
        .load_use             (load_use)
    );

    // Each stall implies every earlier stage also stalls.
    always_comb begin
        mem_stall_raw = mem_mem_wait;
        ex_stall_raw  = mem_stall_raw || (div_busy && ex_hilo_read);
        id_stall_raw  = ex_stall_raw || load_use;
        if_stall_raw  = id_stall_raw || if_mem_wait;
    end

    // Exception FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Exception FSM: next state. The exception is latched on leaving RUN,
    // so DRAIN and FLUSH ignore mem_exception.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (mem_exception) begin
                    state_d = mem_mem_wait ? StDrain : StFlush;
                end
            end
            StDrain: begin
                if (!mem_mem_wait) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Exception FSM: outputs
    always_comb begin
        in_flush     = (state_q == StFlush);
        if_flush     = in_flush;
        id_flush     = in_flush;
        ex_flush     = in_flush;
        mem_flush    = in_flush;
        exc_redirect = in_flush;
        wb_stall     = mem_stall_raw && !in_flush;
        mem_stall    = mem_stall_raw && !in_flush;
        ex_stall     = ex_stall_raw && !in_flush;
        id_stall     = id_stall_raw && !in_flush;
        if_stall     = if_stall_raw && !in_flush;
    end

    // Divider countdown keeps running through stalls; a flush kills it.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (in_flush) begin
            div_cnt_d = '0;
        end else if (ex_div_start && !ex_stall) begin
            div_cnt_d = DivLoad;
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - DivOne;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (if_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + StallOne;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign div_busy     = (div_cnt_q != '0);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_antares_pipeline_sequencer.sv
// Directed self-checking bench for antares_pipeline_sequencer.
module tb_antares_pipeline_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       if_mem_wait, mem_mem_wait;
    logic [4:0] id_rs, id_rt, ex_gpr_wa;
    logic       id_uses_rs, id_uses_rt;
    logic       ex_mem_to_gpr_select, ex_gpr_we, ex_div_start, ex_hilo_read;
    logic       mem_exception;
    logic       if_stall, id_stall, ex_stall, mem_stall, wb_stall;
    logic       if_flush, id_flush, ex_flush, mem_flush, exc_redirect;
    logic       div_busy;
    logic [3:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    antares_pipeline_sequencer #(
        .DIV_CYCLES  (32),
        .STALL_CNT_W (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_mem_wait          (if_mem_wait),
        .mem_mem_wait         (mem_mem_wait),
        .id_rs                (id_rs),
        .id_rt                (id_rt),
        .id_uses_rs           (id_uses_rs),
        .id_uses_rt           (id_uses_rt),
        .ex_gpr_wa            (ex_gpr_wa),
        .ex_mem_to_gpr_select (ex_mem_to_gpr_select),
        .ex_gpr_we            (ex_gpr_we),
        .ex_div_start         (ex_div_start),
        .ex_hilo_read         (ex_hilo_read),
        .mem_exception        (mem_exception),
        .if_stall             (if_stall),
        .id_stall             (id_stall),
        .ex_stall             (ex_stall),
        .mem_stall            (mem_stall),
        .wb_stall             (wb_stall),
        .if_flush             (if_flush),
        .id_flush             (id_flush),
        .ex_flush             (ex_flush),
        .mem_flush            (mem_flush),
        .exc_redirect         (exc_redirect),
        .div_busy             (div_busy),
        .stall_cycles         (stall_cycles)
    );

    always #5 clk = ~clk;

    wire [4:0] stv = {if_stall, id_stall, ex_stall, mem_stall, wb_stall};
    wire [4:0] flv = {if_flush, id_flush, ex_flush, mem_flush, exc_redirect};

    typedef struct packed {
        logic       we;
        logic       ld;
        logic [4:0] wa;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       lu;
    } lu_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_mem_wait          = 1'b0;
        mem_mem_wait         = 1'b0;
        id_rs                = 5'd0;
        id_rt                = 5'd0;
        id_uses_rs           = 1'b0;
        id_uses_rt           = 1'b0;
        ex_gpr_wa            = 5'd0;
        ex_mem_to_gpr_select = 1'b0;
        ex_gpr_we            = 1'b0;
        ex_div_start         = 1'b0;
        ex_hilo_read         = 1'b0;
        mem_exception        = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        n_tests++;
        if (stv !== 5'b00000) begin
            n_fail++; $display("FAIL reset_stalls: got %b want %b", stv, 5'b00000);
        end
        n_tests++;
        if (flv !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flushes: got %b want %b", flv, 5'b00000);
        end
        n_tests++;
        if ({div_busy, stall_cycles} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_counters: got busy=%b cnt=%0d want 0 0",
                               div_busy, stall_cycles);
        end
        mem_mem_wait = 1'b1;
        #1;
        n_tests++;
        if (stv !== 5'b11111) begin
            n_fail++; $display("FAIL reset_memwait_stalls: got %b want %b", stv, 5'b11111);
        end
        mem_mem_wait = 1'b0;
        if_mem_wait  = 1'b1;
        #1;
        n_tests++;
        if (stv !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ifwait_stalls: got %b want %b", stv, 5'b10000);
        end
        tick();
        n_tests++;
        if (stall_cycles !== 4'd0) begin
            n_fail++; $display("FAIL reset_hold_cnt: got %0d want 0", stall_cycles);
        end
        if_mem_wait = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        lu_vec_t v [8];
        v[0] = '{1'b1, 1'b1, 5'd5,  5'd5,  1'b1, 5'd0,  1'b0, 1'b1};
        v[1] = '{1'b1, 1'b1, 5'd0,  5'd5,  1'b1, 5'd0,  1'b0, 1'b0};
        v[2] = '{1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0};
        v[3] = '{1'b1, 1'b1, 5'd7,  5'd3,  1'b1, 5'd7,  1'b1, 1'b1};
        v[4] = '{1'b1, 1'b1, 5'd7,  5'd3,  1'b1, 5'd7,  1'b0, 1'b0};
        v[5] = '{1'b1, 1'b0, 5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0};
        v[6] = '{1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0};
        v[7] = '{1'b1, 1'b1, 5'd31, 5'd31, 1'b0, 5'd30, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            ex_gpr_we            = v[i].we;
            ex_mem_to_gpr_select = v[i].ld;
            ex_gpr_wa            = v[i].wa;
            id_rs                = v[i].rs;
            id_uses_rs           = v[i].urs;
            id_rt                = v[i].rt;
            id_uses_rt           = v[i].urt;
            #1;
            n_tests++;
            if (stv !== (v[i].lu ? 5'b11000 : 5'b00000)) begin
                n_fail++; $display("FAIL load_use_vec%0d: got %b want %b", i, stv,
                                   (v[i].lu ? 5'b11000 : 5'b00000));
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_divider();
        int n;
        clear_inputs();
        ex_div_start = 1'b1;
        #1;
        n_tests++;
        if ({ex_stall, div_busy} !== 2'b00) begin
            n_fail++; $display("FAIL div_start_idle: got stall,busy=%b want 00",
                               {ex_stall, div_busy});
        end
        tick();
        ex_div_start = 1'b0;
        ex_hilo_read = 1'b1;
        #1;
        n_tests++;
        if ({div_busy, stv} !== 6'b111100) begin
            n_fail++; $display("FAIL div_busy_stalls: got busy=%b stalls=%b want 1 11100",
                               div_busy, stv);
        end
        n = 0;
        while (ex_stall && n < 40) begin
            n++;
            tick();
        end
        n_tests++;
        if (n !== 32) begin
            n_fail++; $display("FAIL div_stall_len: got %0d want 32", n);
        end
        n_tests++;
        if ({div_busy, stv} !== 6'b000000) begin
            n_fail++; $display("FAIL div_release: got busy=%b stalls=%b want 0 00000",
                               div_busy, stv);
        end
        // Restart while busy reloads the full count.
        clear_inputs();
        ex_div_start = 1'b1;
        tick();
        ex_div_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ex_div_start = 1'b1;
        tick();
        ex_div_start = 1'b0;
        n = 0;
        while (div_busy && n < 40) begin
            n++;
            tick();
        end
        n_tests++;
        if (n !== 32) begin
            n_fail++; $display("FAIL div_restart_len: got %0d want 32", n);
        end
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        ex_gpr_we            = 1'b1;
        ex_mem_to_gpr_select = 1'b1;
        ex_gpr_wa            = 5'd9;
        id_rt                = 5'd9;
        id_uses_rt           = 1'b1;
        ex_div_start         = 1'b1;
        #1;
        n_tests++;
        if (stv !== 5'b11000) begin
            n_fail++; $display("FAIL lu_div_stalls: got %b want %b", stv, 5'b11000);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (div_busy !== 1'b1) begin
            n_fail++; $display("FAIL lu_div_started: got %b want 1", div_busy);
        end
        for (int i = 0; i < 33; i++) tick();
        n_tests++;
        if (div_busy !== 1'b0) begin
            n_fail++; $display("FAIL lu_div_done: got %b want 0", div_busy);
        end
        // A start while EX is stalled by memory must not launch the divider.
        mem_mem_wait = 1'b1;
        ex_div_start = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (div_busy !== 1'b0) begin
            n_fail++; $display("FAIL div_blocked_by_stall: got %b want 0", div_busy);
        end
    endtask

    task automatic test_exception_idle();
        clear_inputs();
        ex_div_start = 1'b1;
        tick();
        ex_div_start  = 1'b0;
        mem_exception = 1'b1;
        #1;
        n_tests++;
        if (flv !== 5'b00000) begin
            n_fail++; $display("FAIL exc_run_noflush: got %b want %b", flv, 5'b00000);
        end
        tick();
        if_mem_wait = 1'b1;
        #1;
        n_tests++;
        if (flv !== 5'b11111) begin
            n_fail++; $display("FAIL exc_flush_pulse: got %b want %b", flv, 5'b11111);
        end
        n_tests++;
        if (stv !== 5'b00000) begin
            n_fail++; $display("FAIL exc_flush_stalls: got %b want %b", stv, 5'b00000);
        end
        tick();
        n_tests++;
        if (flv !== 5'b00000) begin
            n_fail++; $display("FAIL exc_after_flush: got %b want %b", flv, 5'b00000);
        end
        n_tests++;
        if (div_busy !== 1'b0) begin
            n_fail++; $display("FAIL exc_div_cleared: got %b want 0", div_busy);
        end
        tick();
        n_tests++;
        if (flv !== 5'b11111) begin
            n_fail++; $display("FAIL exc_fresh_event: got %b want %b", flv, 5'b11111);
        end
        clear_inputs();
        tick();
        n_tests++;
        if (flv !== 5'b00000) begin
            n_fail++; $display("FAIL exc_fresh_done: got %b want %b", flv, 5'b00000);
        end
    endtask

    task automatic test_exception_wait();
        clear_inputs();
        mem_exception = 1'b1;
        mem_mem_wait  = 1'b1;
        #1;
        n_tests++;
        if ({flv, stv} !== 10'b00000_11111) begin
            n_fail++; $display("FAIL drain_entry: got fl=%b st=%b want 00000 11111", flv, stv);
        end
        tick();
        mem_exception = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if ({flv, stv} !== 10'b00000_11111) begin
                n_fail++; $display("FAIL drain_hold%0d: got fl=%b st=%b want 00000 11111",
                                   i, flv, stv);
            end
            tick();
        end
        mem_mem_wait = 1'b0;
        #1;
        n_tests++;
        if ({flv, stv} !== 10'b00000_00000) begin
            n_fail++; $display("FAIL drain_last: got fl=%b st=%b want 00000 00000", flv, stv);
        end
        tick();
        n_tests++;
        if (flv !== 5'b11111) begin
            n_fail++; $display("FAIL drain_flush: got %b want %b", flv, 5'b11111);
        end
        tick();
        n_tests++;
        if (flv !== 5'b00000) begin
            n_fail++; $display("FAIL drain_done: got %b want %b", flv, 5'b00000);
        end
    endtask

    task automatic test_reset_mid_drain();
        clear_inputs();
        ex_div_start = 1'b1;
        tick();
        ex_div_start  = 1'b0;
        mem_exception = 1'b1;
        mem_mem_wait  = 1'b1;
        tick();
        mem_exception = 1'b0;
        tick();
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({div_busy, stall_cycles} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_drain_counters: got busy=%b cnt=%0d want 0 0",
                               div_busy, stall_cycles);
        end
        n_tests++;
        if (flv !== 5'b00000) begin
            n_fail++; $display("FAIL rst_drain_flush: got %b want %b", flv, 5'b00000);
        end
        mem_mem_wait = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (flv !== 5'b00000) begin
                n_fail++; $display("FAIL rst_drain_noredirect%0d: got %b want %b",
                                   i, flv, 5'b00000);
            end
        end
    endtask

    task automatic test_stall_saturation();
        int exp_cnt;
        clear_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        n_tests++;
        if (stall_cycles !== 4'd0) begin
            n_fail++; $display("FAIL sat_start: got %0d want 0", stall_cycles);
        end
        if_mem_wait = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_cnt = (i > 15) ? 15 : i;
            n_tests++;
            if (stall_cycles !== exp_cnt[3:0]) begin
                n_fail++; $display("FAIL sat_cycle%0d: got %0d want %0d",
                                   i, stall_cycles, exp_cnt);
            end
        end
        n_tests++;
        if (stv !== 5'b10000) begin
            n_fail++; $display("FAIL sat_stalls: got %b want %b", stv, 5'b10000);
        end
        if_mem_wait = 1'b0;
        tick();
        n_tests++;
        if (stall_cycles !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d want 15", stall_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_divider();
        test_simultaneous();
        test_exception_idle();
        test_exception_wait();
        test_reset_mid_drain();
        test_stall_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/antares_pipeline_sequencer.md
Name: antares_pipeline_sequencer

Overview:
Central stall/flush sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It drives the stall and flush inputs of every inter-stage register, including ID->EX, from these sources:
- memory wait requests
- load-use hazards
- the multi-cycle divider
- exceptions raised in MEM
An exception FSM guarantees the flush happens only once memory is quiescent, then pulses a PC redirect.

Parameters:
DIV_CYCLES, 32, cycles the divider stays busy after ex_div_start
STALL_CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  main clock
rst  in  1  reset, asynchronous, active-low
if_mem_wait  in  1  instruction memory not ready
mem_mem_wait  in  1  data memory not ready
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_gpr_wa  in  5  EX destination register
ex_mem_to_gpr_select  in  1  EX instruction is a load
ex_gpr_we  in  1  EX writes the GPR file
ex_div_start  in  1  divide issued in EX this cycle
ex_hilo_read  in  1  EX instruction reads HI/LO
mem_exception  in  1  exception detected in MEM
if_stall  out  1  hold PC / IF-ID
id_stall  out  1  hold ID; bubble into ID/EX
ex_stall  out  1  hold EX; bubble into EX/MEM
mem_stall  out  1  hold MEM; bubble into MEM/WB
wb_stall  out  1  hold WB
if_flush  out  1  clear IF/ID
id_flush  out  1  clear ID/EX control
ex_flush  out  1  clear EX/MEM control
mem_flush  out  1  clear MEM/WB control
exc_redirect  out  1  one-cycle pulse: load exception vector into PC
div_busy  out  1  divider running
stall_cycles  out  STALL_CNT_W  cycles with if_stall high, saturating

Behaviour:
Reset (rst=0, asynchronous):
- state=RUN, div_cnt=0, stall_cycles=0
- all flush outputs, exc_redirect and div_busy are 0
- stalls are 0 except those forced by the memory-wait inputs.

Load-use hazard (combinational):
- load_use = ex_gpr_we & ex_mem_to_gpr_select & ex_gpr_wa!=0 & ((id_uses_rs & id_rs==ex_gpr_wa) | (id_uses_rt & id_rt==ex_gpr_wa)).

Stall chain (combinational, each stage implies all earlier stages):
- wb_stall = mem_stall = mem_mem_wait
- ex_stall = mem_stall | (div_busy & ex_hilo_read)
- id_stall = ex_stall | load_use
- if_stall = id_stall | if_mem_wait
- Stall outputs are forced to 0 in state FLUSH.

Divider counter:
- On ex_div_start with ex_stall=0: div_cnt <= DIV_CYCLES.
- Otherwise, if div_cnt!=0: decrement by 1 each cycle, including stall cycles.
- div_busy = (div_cnt!=0).
- A start while div_busy restarts the count.

Exception FSM:
- RUN:
  - mem_exception & !mem_mem_wait -> FLUSH
  - mem_exception & mem_mem_wait -> DRAIN
- DRAIN: hold while mem_mem_wait=1; when mem_mem_wait=0 -> FLUSH. A withdrawn mem_exception is ignored; the exception is latched at RUN exit.
- FLUSH (exactly 1 cycle): if_flush=id_flush=ex_flush=mem_flush=1, exc_redirect=1, div_cnt cleared to 0 -> RUN.
- A new mem_exception in the cycle after FLUSH is handled as a fresh event.
- Flush outputs are 0 in RUN and DRAIN; latency from mem_exception (memory idle) to the flush cycle is 1 cycle.

stall_cycles: increments when if_stall=1; saturates at all-ones; never wraps.

Simultaneous events:
- load_use together with ex_div_start: the divide still starts, because EX is not stalled.
- mem_exception during the FLUSH cycle is ignored.
- Reset mid-DRAIN returns to RUN immediately and emits no redirect.

Decomposition:
- Shared package/header: FSM state encodings (RUN=2'd0, DRAIN=2'd1, FLUSH=2'd2), the DIV_CYCLES default, and the GPR index width constant (5).
- One natural sub-module: antares_load_use_detector (pure combinational compare). Counters and FSM stay in the top.

Test Plan:
1. Load-use: ex_gpr_we=1, ex_mem_to_gpr_select=1, ex_gpr_wa=5, id_rs=5, id_uses_rs=1 -> id_stall=if_stall=1, ex_stall=0 for 1 cycle. Same stimulus with ex_gpr_wa=0 -> no stall.
2. Divider: pulse ex_div_start, then hold ex_hilo_read=1 -> ex_stall=1 for exactly 32 cycles, div_busy falls on the 33rd cycle, then the stall releases.
3. Exception while memory idle: mem_exception=1 in cycle N -> all four flushes and exc_redirect high in cycle N+1 only, stalls 0 in that cycle.
4. Exception during memory wait: mem_exception with mem_mem_wait=1 for 3 cycles -> state DRAIN for 3 cycles, no flush; flush pulse one cycle after mem_mem_wait falls.
5. Async reset asserted mid-DRAIN, between clock edges -> state=RUN, div_busy=0, stall_cycles=0 immediately; no exc_redirect after release.
6. Counter saturation with STALL_CNT_W=4: hold if_mem_wait=1 for 20 cycles -> stall_cycles reaches 15 and stays at 15.
